// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the Tetris button conditioning block: button
// indices, default 50 MHz timing constants and the repeat FSM encoding.
package btn_debounce_pkg;

    // Button channel indices as wired on the player panel
    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_ROT   = 2;
    localparam int BTN_DROP  = 3;
    localparam int BTN_PAUSE = 4;

    // Default timing at 50 MHz
    localparam int DEF_NUM_BTN         = 5;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms
    localparam int DEF_REPEAT_DELAY    = 10000000;  // 200 ms
    localparam int DEF_REPEAT_RATE     = 2500000;   // 50 ms
    localparam int DEF_CNT_W           = 24;

    // Auto-repeat state per channel
    typedef enum logic [1:0] {
        RP_IDLE   = 2'd0,
        RP_DELAY  = 2'd1,
        RP_REPEAT = 2'd2
    } rp_state_e;

endpackage

// File: rtl/btn_channel.sv
// Single button channel: debounce to a stable level, registered press and
// release strobes, and an auto-repeat FSM that adds extra press strobes
// while the button stays held.
module btn_channel
    import btn_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_sync,
    input  logic repeat_en,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] db_cnt_r;
    logic [CNT_W-1:0] db_cnt_s;
    logic [CNT_W-1:0] rp_cnt_r;
    logic [CNT_W-1:0] rp_cnt_s;
    rp_state_e        state_r;
    rp_state_e        state_s;
    logic             level_r;
    logic             level_s;
    logic             press_r;
    logic             press_s;
    logic             release_r;
    logic             release_s;
    logic             accept_s;
    logic             rise_s;
    logic             fall_s;
    logic             rp_pulse_s;

    // Debounce window: count while input disagrees with level, any agreement restarts it
    always_comb begin
        db_cnt_s = CNT_ZERO;
        level_s  = level_r;
        accept_s = 1'b0;
        if (btn_sync != level_r) begin
            if (db_cnt_r == DB_LAST) begin
                accept_s = 1'b1;
                level_s  = btn_sync;
                db_cnt_s = CNT_ZERO;
            end else begin
                db_cnt_s = db_cnt_r + CNT_ONE;
            end
        end else begin
            db_cnt_s = CNT_ZERO;
        end
        rise_s = accept_s & btn_sync;
        fall_s = accept_s & ~btn_sync;
    end

    // Auto-repeat next-state: a release or disable wins over a pending repeat pulse
    always_comb begin
        state_s    = state_r;
        rp_cnt_s   = rp_cnt_r;
        rp_pulse_s = 1'b0;
        case (state_r)
            RP_IDLE: begin
                rp_cnt_s = CNT_ZERO;
                if (rise_s && repeat_en) begin
                    state_s = RP_DELAY;
                end else begin
                    state_s = RP_IDLE;
                end
            end
            RP_DELAY: begin
                if (fall_s || !repeat_en) begin
                    state_s  = RP_IDLE;
                    rp_cnt_s = CNT_ZERO;
                end else if (rp_cnt_r == RD_LAST) begin
                    state_s    = RP_REPEAT;
                    rp_cnt_s   = CNT_ZERO;
                    rp_pulse_s = 1'b1;
                end else begin
                    rp_cnt_s = rp_cnt_r + CNT_ONE;
                end
            end
            RP_REPEAT: begin
                if (fall_s || !repeat_en) begin
                    state_s  = RP_IDLE;
                    rp_cnt_s = CNT_ZERO;
                end else if (rp_cnt_r == RR_LAST) begin
                    rp_cnt_s   = CNT_ZERO;
                    rp_pulse_s = 1'b1;
                end else begin
                    rp_cnt_s = rp_cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s  = RP_IDLE;
                rp_cnt_s = CNT_ZERO;
            end
        endcase
        press_s   = rise_s | rp_pulse_s;
        release_s = fall_s;
    end

    // Channel state and registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_r  <= CNT_ZERO;
            rp_cnt_r  <= CNT_ZERO;
            state_r   <= RP_IDLE;
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            db_cnt_r  <= db_cnt_s;
            rp_cnt_r  <= rp_cnt_s;
            state_r   <= state_s;
            level_r   <= level_s;
            press_r   <= press_s;
            release_r <= release_s;
        end
    end

    assign btn_level   = level_r;
    assign btn_press   = press_r;
    assign btn_release = release_r;

endmodule

// File: rtl/btn_debounce.sv
// Button conditioning top: one independent btn_channel per player button.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int NUM_BTN         = DEF_NUM_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_sync,
    input  logic [NUM_BTN-1:0] repeat_en,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .btn_sync    (btn_sync[i]),
            .repeat_en   (repeat_en[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce with short timing constants.
// A per-channel event model (stability run length, press age) predicts
// every output each cycle.
module tb_btn_debounce;

    localparam int NB = 5;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] btn_sync;
    logic [NB-1:0] repeat_en;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;

    btn_debounce #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR),
        .CNT_W           (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_sync    (btn_sync),
        .repeat_en   (repeat_en),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic [NB-1:0] m_level;
    logic [NB-1:0] m_press;
    logic [NB-1:0] m_release;
    int            m_run   [NB];
    bit            m_armed [NB];
    int            m_age   [NB];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_level   = '0;
        m_press   = '0;
        m_release = '0;
        for (int i = 0; i < NB; i++) begin
            m_run[i]   = 0;
            m_armed[i] = 0;
            m_age[i]   = 0;
        end
    endtask

    // One clock edge of the behaviour: a level flips once the input has
    // disagreed for DB consecutive samples; held presses repeat at age
    // RD, RD+RR, RD+2RR, ... while enable stays high.
    task automatic model_step();
        bit acc;
        m_press   = '0;
        m_release = '0;
        for (int i = 0; i < NB; i++) begin
            acc = 0;
            if (btn_sync[i] != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_level[i] = btn_sync[i];
                    m_run[i]   = 0;
                    acc        = 1;
                end
            end else begin
                m_run[i] = 0;
            end
            if (m_armed[i]) begin
                if ((acc && !m_level[i]) || !repeat_en[i]) begin
                    m_armed[i] = 0;
                end else begin
                    m_age[i]++;
                    if (m_age[i] >= RD && ((m_age[i] - RD) % RR) == 0) m_press[i] = 1'b1;
                end
            end
            if (acc) begin
                if (m_level[i]) begin
                    m_press[i] = 1'b1;
                    if (repeat_en[i]) begin
                        m_armed[i] = 1;
                        m_age[i]   = 0;
                    end
                end else begin
                    m_release[i] = 1'b1;
                end
            end
        end
    endtask

    // Apply inputs, let one edge happen, compare all outputs at the falling edge
    task automatic cycle(input logic [NB-1:0] s, input logic [NB-1:0] en, input string tag);
        btn_sync  = s;
        repeat_en = en;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq({tag, "_level"},   32'(btn_level),   32'(m_level));
        check_eq({tag, "_press"},   32'(btn_press),   32'(m_press));
        check_eq({tag, "_release"}, 32'(btn_release), 32'(m_release));
    endtask

    int pc;
    logic [NB-1:0] rs;
    logic [NB-1:0] ren;

    initial begin
        rst_n     = 1'b0;
        btn_sync  = '0;
        repeat_en = '0;
        model_reset();
        #1;
        check_eq("reset_out", 32'({btn_level, btn_press, btn_release}), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // clean press on ch0 without repeat
        for (int k = 0; k < DB - 1; k++) cycle(5'b00001, 5'b00000, "press0");
        check_eq("press0_early", 32'(btn_level[0]), 32'h0);
        cycle(5'b00001, 5'b00000, "press0");
        check_eq("press0_strobe", 32'(btn_press), 32'h1);
        pc = 0;
        for (int k = 0; k < 50; k++) begin
            cycle(5'b00001, 5'b00000, "hold0");
            pc += int'(btn_press[0]);
        end
        check_eq("hold0_nopulse", 32'(pc), 32'h0);
        for (int k = 0; k < DB; k++) cycle(5'b00000, 5'b00000, "rel0");
        check_eq("rel0_strobe", 32'(btn_release), 32'h1);

        // glitchy input never settles long enough
        pc = 0;
        for (int k = 0; k < 10; k++) begin
            cycle((k == 3 || k >= 7) ? 5'b00000 : 5'b00001, 5'b00000, "glitch");
            pc += int'(btn_press[0]) + int'(btn_release[0]) + int'(btn_level[0]);
        end
        check_eq("glitch_quiet", 32'(pc), 32'h0);

        // auto-repeat on ch1
        for (int k = 0; k < DB; k++) cycle(5'b00010, 5'b00010, "rp1");
        check_eq("rp1_first", 32'(btn_press), 32'h2);
        pc = 0;
        for (int k = 0; k < 30; k++) begin
            cycle(5'b00010, 5'b00010, "rp1_hold");
            pc += int'(btn_press[1]);
        end
        check_eq("rp1_count", 32'(pc), 32'h7);
        for (int k = 0; k < DB; k++) cycle(5'b00000, 5'b00010, "rp1_rel");
        check_eq("rp1_rel_strobe", 32'(btn_release), 32'h2);
        check_eq("rp1_rel_nopress", 32'(btn_press), 32'h0);
        pc = 0;
        for (int k = 0; k < 15; k++) begin
            cycle(5'b00000, 5'b00010, "rp1_after");
            pc += int'(btn_press[1]);
        end
        check_eq("rp1_after_count", 32'(pc), 32'h0);

        // repeat disabled while in the repeat phase on ch2
        for (int k = 0; k < DB + 14; k++) cycle(5'b00100, 5'b00100, "en2");
        pc = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(5'b00100, 5'b00000, "en2_off");
            pc += int'(btn_press[2]);
        end
        check_eq("en2_off_count", 32'(pc), 32'h0);
        check_eq("en2_level", 32'(btn_level), 32'h4);
        for (int k = 0; k < DB; k++) cycle(5'b00000, 5'b00000, "en2_rel");

        // simultaneous presses on ch0 and ch4
        for (int k = 0; k < DB; k++) cycle(5'b10001, 5'b00000, "sim");
        check_eq("sim_press", 32'(btn_press), 32'h11);
        for (int k = 0; k < DB; k++) cycle(5'b00000, 5'b00000, "sim_rel");
        check_eq("sim_release", 32'(btn_release), 32'h11);

        // asynchronous reset in the middle of a hold on ch3
        for (int k = 0; k < DB + 3; k++) cycle(5'b01000, 5'b00000, "rst3");
        check_eq("rst3_level", 32'(btn_level), 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst3_async", 32'({btn_level, btn_press, btn_release}), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < DB; k++) cycle(5'b01000, 5'b00000, "rst3_redb");
        check_eq("rst3_press", 32'(btn_press), 32'h8);
        for (int k = 0; k < DB; k++) cycle(5'b00000, 5'b00000, "rst3_rel");

        // randomized phase: sticky random buttons and rarely changing enables
        rs  = '0;
        ren = NB'($urandom);
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 7) == 0) rs[i] = ~rs[i];
                if ($urandom_range(0, 63) == 0) ren[i] = ~ren[i];
            end
            cycle(rs, ren, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
